// File: rtl/alu_pkg.sv
// Shared opcode map and sequencer state type for the shared-ALU arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_DIV   = 4'b0110;
  localparam logic [3:0] ALU_MOD   = 4'b0111;
  localparam logic [3:0] ALU_SHL   = 4'b1000;
  localparam logic [3:0] ALU_SHR   = 4'b1001;
  localparam logic [3:0] ALU_NAND  = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1011;
  localparam logic [3:0] ALU_XNOR  = 4'b1100;
  localparam logic [3:0] ALU_PASSA = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1110;
  localparam logic [3:0] ALU_NADD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_div_zero(input logic [3:0] op, input logic b_zero);
    return ((op == ALU_DIV) || (op == ALU_MOD)) && b_zero;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request above `last`, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j_s;
  logic          hit_s;
  logic          found_s;

  // Scan upward from last+1 and keep only the first hit
  always_comb begin
    gnt     = '0;
    idx     = '0;
    j_s     = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j_s      = IW'((int'(last) + k) % NREQ);
      hit_s    = !found_s && req[j_s];
      gnt[j_s] = gnt[j_s] | hit_s;
      idx      = hit_s ? j_s : idx;
      found_s  = found_s | hit_s;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational ALU among NREQ requesters,
// with divide/modulo-by-zero trapped before the result is returned.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int RW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [RW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic [3:0]        alu_st,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [RW-1:0]     alu_res,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_r;
  logic [IW-1:0]   last_r;
  logic [IW-1:0]   gidx_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [3:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [RW-1:0]   res_r;
  logic            err_r;
  logic            busy_r;

  logic [NREQ-1:0] pick_gnt_s;
  logic [IW-1:0]   pick_idx_s;
  logic [3:0]      sel_op_s;
  logic [W-1:0]    sel_a_s;
  logic [W-1:0]    sel_b_s;
  logic            div_zero_s;
  logic            rsp_acc_s;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req (req_valid),
    .last(last_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // AND-OR operand mux driven by the one-hot pick
  always_comb begin
    sel_op_s = '0;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_op_s = sel_op_s | (req_op[4*i +: 4] & {4{pick_gnt_s[i]}});
      sel_a_s  = sel_a_s  | (req_a[W*i +: W]  & {W{pick_gnt_s[i]}});
      sel_b_s  = sel_b_s  | (req_b[W*i +: W]  & {W{pick_gnt_s[i]}});
    end
  end

  // Same-cycle accept; gated by rst_n so it also drops while reset is held
  always_comb begin
    if (rst_n && (state_r == IDLE)) begin
      req_ready = pick_gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  assign div_zero_s = is_div_zero(op_r, (b_r == '0));
  assign rsp_acc_s  = |(rsp_ready & gnt_r);

  // Sequencer: latch request, capture result, hold response until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_r      <= IW'(NREQ - 1);
      gidx_r      <= '0;
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_valid) begin
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            gnt_r   <= pick_gnt_s;
            gidx_r  <= pick_idx_s;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (div_zero_s) begin
            res_r <= {RW{1'b1}};
            err_r <= 1'b1;
          end else begin
            res_r <= alu_res;
            err_r <= 1'b0;
          end
          rsp_valid_r <= gnt_r;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_acc_s) begin
            last_r      <= gidx_r;
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = res_r;
  assign rsp_err   = err_r;
  assign alu_st    = op_r;
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and randomized bench for alu_share_arb against a transaction-level model.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int RW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [RW-1:0]     rsp_data;
  logic              rsp_err;
  logic [3:0]        alu_st;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [RW-1:0]     alu_res;
  logic              busy;

  logic              r_v  [NREQ];
  logic [3:0]        r_op [NREQ];
  logic [W-1:0]      r_a  [NREQ];
  logic [W-1:0]      r_b  [NREQ];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit refill = 1'b0;

  // transaction model: 0 = free, 1 = one cycle after accept, 2 = response pending
  int            m_phase;
  int            m_last;
  int            m_g;
  logic [3:0]    m_op;
  logic [W-1:0]  m_a;
  logic [W-1:0]  m_b;
  logic [RW-1:0] m_res;
  logic          m_err;
  int            grants[$];
  int            acc_cyc[$];
  int            exp_order[5] = '{0, 1, 2, 3, 0};

  alu_share_arb #(.NREQ(NREQ), .W(W), .RW(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .alu_st   (alu_st),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_res  (alu_res),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide/modulo by zero deliberately return 0, not all-ones
  function automatic logic [RW-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      4'd0:    r = ia & ib;
      4'd1:    r = ia | ib;
      4'd2:    r = ia ^ ib;
      4'd3:    r = ia + ib;
      4'd4:    r = ia - ib;
      4'd5:    r = ia * ib;
      4'd6:    r = (ib == 0) ? 0 : ia / ib;
      4'd7:    r = (ib == 0) ? 0 : ia % ib;
      4'd8:    r = ia << 1;
      4'd9:    r = ia >> 1;
      4'd10:   r = ~(ia & ib);
      4'd11:   r = ~(ia | ib);
      4'd12:   r = ~(ia ^ ib);
      4'd13:   r = ia;
      4'd14:   r = ib;
      default: r = -(ia + ib);
    endcase
    return r[RW-1:0];
  endfunction

  always_comb alu_res = alu_fn(alu_st, alu_a, alu_b);

  always_comb begin
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = r_v[i];
      req_op[4*i +: 4]  = r_op[i];
      req_a[W*i +: W]   = r_a[i];
      req_b[W*i +: W]   = r_b[i];
    end
  end

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  function automatic int rr_next(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] t;
    for (int k = 1; k <= NREQ; k++) begin
      t = v >> ((last + k) % NREQ);
      if (t[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 32'd0);
    chk({tag, "_rsp_valid"}, rsp_valid, 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,  32'd0);
    chk({tag, "_rsp_err"},   rsp_err,   32'd0);
    chk({tag, "_alu_st"},    alu_st,    32'd0);
    chk({tag, "_alu_a"},     alu_a,     32'd0);
    chk({tag, "_alu_b"},     alu_b,     32'd0);
    chk({tag, "_busy"},      busy,      32'd0);
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    r_v[r]  = 1'b1;
    r_op[r] = op;
    r_a[r]  = a;
    r_b[r]  = b;
  endtask

  task automatic new_req(input int r);
    set_req(r, 4'($urandom_range(0, 15)), W'($urandom),
            ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = NREQ - 1;
  endtask

  // Called at posedge+1 with inputs set; checks at posedge+2, then advances one cycle
  task automatic step();
    int g;
    logic [NREQ-1:0] t;
    #1;
    cyc++;
    g = (m_phase == 0) ? rr_next(req_valid, m_last) : -1;
    chk("req_ready", req_ready, (g >= 0) ? oh(g) : '0);
    chk("busy", busy, m_phase != 0);
    chk("rsp_valid", rsp_valid, (m_phase == 2) ? oh(m_g) : '0);
    if (m_phase == 2) begin
      chk("rsp_data", rsp_data, m_res);
      chk("rsp_err", rsp_err, m_err);
    end
    if (m_phase != 0) begin
      chk("alu_st", alu_st, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
    for (int i = 0; i < NREQ; i++) begin
      t = req_ready >> i;
      if (t[0]) begin
        grants.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    if (g >= 0) begin
      m_g  = g;
      m_op = r_op[g];
      m_a  = r_a[g];
      m_b  = r_b[g];
      if ((m_op == 4'd6 || m_op == 4'd7) && m_b == '0) begin
        m_res = 5'h1f;
        m_err = 1'b1;
      end else begin
        m_res = alu_fn(m_op, m_a, m_b);
        m_err = 1'b0;
      end
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && (rsp_ready & oh(m_g)) != '0) begin
      m_last  = m_g;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (refill) new_req(g);
      else r_v[g] = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_v[i] = 1'b0; r_op[i] = 4'd0; r_a[i] = '0; r_b[i] = '0;
    end
    r_v[0] = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    r_v[0] = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    // All requesters continuously valid, responses always accepted
    grants.delete();
    acc_cyc.delete();
    rsp_ready = '1;
    refill    = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    repeat (15) step();
    refill = 1'b0;
    for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
    step();
    chk("rr_count", grants.size(), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], exp_order[i]);
    for (int i = 1; i < acc_cyc.size(); i++) chk("rr_interval", acc_cyc[i] - acc_cyc[i-1], 32'd3);

    // Requester 0: 3 + 4
    set_req(0, ALU_ADD, 4'd3, 4'd4);
    #1;
    chk("add_ready", req_ready, 4'b0001);
    step();
    step();
    #1;
    chk("add_valid", rsp_valid, 4'b0001);
    chk("add_data", rsp_data, 5'd7);
    chk("add_err", rsp_err, 1'b0);
    step();
    step();

    // Requester 1 response held off while requester 3 waits; other ready bits ignored
    rsp_ready = 4'b1101;
    set_req(1, ALU_MUL, 4'd5, 4'd3);
    step();
    set_req(3, ALU_SUB, 4'd5, 4'd2);
    step();
    repeat (5) step();
    rsp_ready = 4'b0010;
    step();
    #1;
    chk("hold_grant3", req_ready, 4'b1000);
    step();
    rsp_ready = '1;
    step();
    step();
    step();

    // Divide by zero trapped, then a legal divide
    set_req(2, ALU_DIV, 4'd9, 4'd0);
    step();
    step();
    #1;
    chk("dz_data", rsp_data, 5'h1f);
    chk("dz_err", rsp_err, 1'b1);
    step();
    set_req(2, ALU_DIV, 4'd9, 4'd3);
    step();
    step();
    #1;
    chk("div_data", rsp_data, 5'd3);
    chk("div_err", rsp_err, 1'b0);
    step();
    step();

    // Reset during RESP, then requester 1 withdraws while 0 holds the grant
    set_req(0, ALU_XOR, 4'd6, 4'd5);
    step();
    step();
    set_req(1, ALU_OR, 4'd1, 4'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_resp");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, ALU_AND, 4'd12, 4'd10);
    set_req(1, ALU_NOR, 4'd3, 4'd4);
    set_req(2, ALU_NADD, 4'd7, 4'd8);
    #1;
    chk("post_rst_grant0", req_ready, 4'b0001);
    chk("post_rst_no_rsp", rsp_valid, 4'b0000);
    step();
    r_v[1] = 1'b0;
    step();
    step();
    #1;
    chk("skip_grant2", req_ready, 4'b0100);
    step();
    step();
    step();

    // Randomized traffic
    repeat (500) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!r_v[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (r_v[i] && $urandom_range(0, 31) == 0) r_v[i] = 1'b0;
      end
      rsp_ready = NREQ'($urandom);
      step();
    end
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
